// File: rtl/reg_pipe_pkg.sv
// Shared sizing helpers for the stallable register pipeline.
package reg_pipe_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_if.sv
// Valid/ready/data handshake bundle; master drives valid and data, slave drives ready.
interface reg_pipe_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/reg_pipe_stage.sv
// One pipeline slot: a valid flop plus a data flop that only captures real words.
module reg_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Bubbles advance through the valid bit but never overwrite the data register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/reg_pipe_stall.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing and synchronous flush.
// Define REG_PIPE_OCCUPANCY_EN to add the registered occupancy count port.
module reg_pipe_stall
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  reg_pipe_if.slave  up,
  reg_pipe_if.master dn
`ifdef REG_PIPE_OCCUPANCY_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  logic             v   [DEPTH];
  logic [WIDTH-1:0] d   [DEPTH];
  logic             rdy [DEPTH];

  // A stage can load if it is empty or everything ahead of it can move.
  always_comb begin : ready_chain
    logic chain;
    chain = dn.ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain  = chain | !v[k];
      rdy[k] = chain;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (k == 0) begin : g_head
      assign src_valid = up.valid;
      assign src_data  = up.data;
    end else begin : g_body
      assign src_valid = v[k-1];
      assign src_data  = d[k-1];
    end

    reg_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .clear    (flush),
      .load     (rdy[k]),
      .in_valid (src_valid),
      .in_data  (src_data),
      .valid    (v[k]),
      .data     (d[k])
    );
  end

  assign up.ready = rdy[0] & !flush;
  assign dn.valid = v[DEPTH-1] & !flush;
  assign dn.data  = d[DEPTH-1];

`ifdef REG_PIPE_OCCUPANCY_EN
  logic in_hs;
  logic out_hs;

  assign in_hs  = up.valid & up.ready;
  assign out_hs = dn.valid & dn.ready;

  // Simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_hs && !out_hs) begin
      occupancy <= occupancy + 1'b1;
    end else if (!in_hs && out_hs) begin
      occupancy <= occupancy - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_pipe_stall.sv
// Bench for reg_pipe_stall: directed vectors on a 3x8 instance, then randomized runs
// on 3x8 and 1x1 instances against a slot-position reference model and scoreboard.
module tb_reg_pipe_stall;

  logic clk;
  logic reset;
  logic flush;
  int   checks;
  int   failures;
  int   sel;

  reg_pipe_if #(.WIDTH(8)) up_a ();
  reg_pipe_if #(.WIDTH(8)) dn_a ();
  reg_pipe_if #(.WIDTH(1)) up_b ();
  reg_pipe_if #(.WIDTH(1)) dn_b ();

`ifdef REG_PIPE_OCCUPANCY_EN
  logic [1:0] occ_a;
  logic [0:0] occ_b;
`endif

  reg_pipe_stall #(.WIDTH(8), .DEPTH(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .up    (up_a),
    .dn    (dn_a)
`ifdef REG_PIPE_OCCUPANCY_EN
    ,
    .occupancy (occ_a)
`endif
  );

  reg_pipe_stall #(.WIDTH(1), .DEPTH(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .up    (up_b),
    .dn    (dn_b)
`ifdef REG_PIPE_OCCUPANCY_EN
    ,
    .occupancy (occ_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       expOv;
    logic [7:0] expOd;
    logic       expIr;
    int         expOcc;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         pos;
  } slot_t;

  vec_t       vecs[$];
  slot_t      mq[$];
  logic [7:0] sbq[$];
  logic [7:0] mLast;
  int         mDepth;
  logic [7:0] mMask;

  function automatic void addVec(input logic iv, input logic [7:0] id, input logic ordy,
                                 input logic ov, input logic [7:0] od, input logic ir,
                                 input int occ);
    vecs.push_back('{iv, id, ordy, ov, od, ir, occ});
  endfunction

  // Reference model: queue of words with their stage position, oldest first.
  function automatic void modelReset(input int depth, input logic [7:0] mask);
    mq.delete();
    mLast  = 8'h00;
    mDepth = depth;
    mMask  = mask;
  endfunction

  function automatic void modelPredict(input logic ordy, input logic fl, output logic ov,
                                       output logic [7:0] od, output logic ir, output int occ);
    ov  = !fl && (mq.size() > 0) && (mq[0].pos == mDepth - 1);
    od  = mLast;
    ir  = !fl && ((mq.size() < mDepth) || ordy);
    occ = mq.size();
  endfunction

  function automatic void modelStep(input logic iv, input logic [7:0] id, input logic ordy,
                                    input logic fl);
    logic inHs;
    int   limit;
    int   nxt;
    if (fl) begin
      mq.delete();
      return;
    end
    inHs = iv && ((mq.size() < mDepth) || ordy);
    if ((mq.size() > 0) && (mq[0].pos == mDepth - 1) && ordy) void'(mq.pop_front());
    limit = mDepth - 1;
    for (int i = 0; i < mq.size(); i++) begin
      nxt = (mq[i].pos + 1 <= limit) ? mq[i].pos + 1 : mq[i].pos;
      if ((nxt != mq[i].pos) && (nxt == mDepth - 1)) mLast = mq[i].data;
      mq[i].pos = nxt;
      limit = nxt - 1;
    end
    if (inHs) begin
      mq.push_back('{id & mMask, 0});
      if (mDepth == 1) mLast = id & mMask;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkOcc(input string name, input int expected);
`ifdef REG_PIPE_OCCUPANCY_EN
    logic [31:0] a;
    a = (sel == 0) ? 32'(occ_a) : 32'(occ_b);
    checkOutput(name, a, expected);
`endif
  endtask

  task automatic readOutputs(output logic ov, output logic [7:0] od, output logic ir);
    if (sel == 0) begin
      ov = dn_a.valid;
      od = dn_a.data;
      ir = up_a.ready;
    end else begin
      ov = dn_b.valid;
      od = {7'b0, dn_b.data};
      ir = up_b.ready;
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic iv, input logic [7:0] id, input logic ordy,
                               input logic fl);
    @(negedge clk);
    up_a.valid = 1'b0; up_a.data = 8'h00; dn_a.ready = 1'b1;
    up_b.valid = 1'b0; up_b.data = 1'b0;  dn_b.ready = 1'b1;
    if (sel == 0) begin
      up_a.valid = iv; up_a.data = id; dn_a.ready = ordy;
    end else begin
      up_b.valid = iv; up_b.data = id[0]; dn_b.ready = ordy;
    end
    flush = fl;
    #1;
  endtask

  task automatic expectOut(input string tag, input logic ov, input logic [7:0] od,
                           input logic ir);
    logic       aOv;
    logic [7:0] aOd;
    logic       aIr;
    readOutputs(aOv, aOd, aIr);
    checkOutput({tag, "_out_valid"}, aOv, ov);
    checkOutput({tag, "_out_data"}, aOd, od);
    checkOutput({tag, "_in_ready"}, aIr, ir);
  endtask

  task automatic randomRun(input int depth, input logic [7:0] mask, input int cycles);
    logic       pendValid;
    logic [7:0] pendData;
    logic       ordy;
    logic       fl;
    logic       eOv, eIr, aOv, aIr;
    logic [7:0] eOd, aOd;
    int         eOcc;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    modelReset(depth, mask);
    sbq.delete();
    pendValid = 1'b0;
    pendData  = 8'h00;
    for (int n = 0; n < cycles + depth + 6; n++) begin
      if (n < cycles && !pendValid && $urandom_range(0, 3) != 0) begin
        pendValid = 1'b1;
        pendData  = 8'($urandom) & mask;
      end
      ordy = (n < cycles) ? 1'($urandom_range(0, 1)) : 1'b1;
      fl   = (n < cycles) && ($urandom_range(0, 24) == 0);
      applyStimulus(pendValid, pendData, ordy, fl);
      modelPredict(ordy, fl, eOv, eOd, eIr, eOcc);
      readOutputs(aOv, aOd, aIr);
      checkOutput("rand_out_valid", aOv, eOv);
      checkOutput("rand_out_data", aOd, eOd);
      checkOutput("rand_in_ready", aIr, eIr);
      checkOcc("rand_occupancy", eOcc);
      if (fl) begin
        sbq.delete();
      end else begin
        if (aOv && ordy) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_dup: got word %0h, expected no word", aOd);
          end else begin
            checkOutput("sb_order", aOd, sbq.pop_front());
          end
        end
        if (pendValid && aIr) sbq.push_back(pendData);
      end
      @(posedge clk);
      modelStep(pendValid, pendData, ordy, fl);
      if (pendValid && eIr) pendValid = 1'b0;
    end
    checkOutput("sb_drain_left", sbq.size(), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    sel      = 0;
    reset    = 1'b0;
    flush    = 1'b0;
    up_a.valid = 1'b0; up_a.data = 8'h00; dn_a.ready = 1'b0;
    up_b.valid = 1'b0; up_b.data = 1'b0;  dn_b.ready = 1'b0;

    #12;
    expectOut("reset", 1'b0, 8'h00, 1'b1);
    checkOcc("reset_occ", 0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] streaming and fill/stall vectors");
    addVec(1, 8'h11, 1, 0, 8'h00, 1, 0);
    addVec(1, 8'h22, 1, 0, 8'h00, 1, 1);
    addVec(1, 8'h33, 1, 0, 8'h00, 1, 2);
    addVec(1, 8'h44, 1, 1, 8'h11, 1, 3);
    addVec(0, 8'h00, 1, 1, 8'h22, 1, 3);
    addVec(0, 8'h00, 1, 1, 8'h33, 1, 2);
    addVec(0, 8'h00, 1, 1, 8'h44, 1, 1);
    addVec(0, 8'h00, 1, 0, 8'h44, 1, 0);
    addVec(1, 8'hA1, 0, 0, 8'h44, 1, 0);
    addVec(1, 8'hA2, 0, 0, 8'h44, 1, 1);
    addVec(1, 8'hA3, 0, 0, 8'h44, 1, 2);
    addVec(1, 8'hA4, 0, 1, 8'hA1, 0, 3);
    addVec(1, 8'hA4, 0, 1, 8'hA1, 0, 3);
    addVec(1, 8'hA4, 1, 1, 8'hA1, 1, 3);
    addVec(0, 8'h00, 1, 1, 8'hA2, 1, 3);
    addVec(0, 8'h00, 1, 1, 8'hA3, 1, 2);
    addVec(0, 8'h00, 1, 1, 8'hA4, 1, 1);
    addVec(0, 8'h00, 1, 0, 8'hA4, 1, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].iv, vecs[i].id, vecs[i].ordy, 1'b0);
      expectOut($sformatf("vec%0d", i), vecs[i].expOv, vecs[i].expOd, vecs[i].expIr);
      checkOcc($sformatf("vec%0d_occ", i), vecs[i].expOcc);
    end

    $display("[TB] bubble collapse");
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0); expectOut("bub0", 1'b0, 8'hA4, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); expectOut("bub1", 1'b0, 8'hA4, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); expectOut("bub2", 1'b0, 8'hA4, 1'b1);
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0); expectOut("bub3", 1'b1, 8'h55, 1'b1);
    checkOcc("bub3_occ", 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0); expectOut("bub4", 1'b1, 8'h55, 1'b1);
    checkOcc("bub4_occ", 2);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); expectOut("bub5", 1'b1, 8'h55, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); expectOut("bub6", 1'b1, 8'h66, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); expectOut("bub7", 1'b0, 8'h66, 1'b1);

    $display("[TB] flush with pending input");
    applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hB3, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1); expectOut("flush", 1'b0, 8'hB1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0); expectOut("post_flush", 1'b0, 8'hB1, 1'b1);
    checkOcc("post_flush_occ", 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      expectOut($sformatf("flush_drain%0d", i), 1'b0, 8'hB1, 1'b1);
    end

    $display("[TB] async reset while stalled");
    applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0); expectOut("full_stall", 1'b1, 8'hC1, 1'b0);
    #2 reset = 1'b0;
    #1 expectOut("async_reset", 1'b0, 8'h00, 1'b1);
    checkOcc("async_reset_occ", 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      expectOut($sformatf("after_reset%0d", i), 1'b0, 8'h00, 1'b1);
    end

    $display("[TB] randomized run, DEPTH=3 WIDTH=8");
    sel = 0;
    randomRun(3, 8'hFF, 400);
    $display("[TB] randomized run, DEPTH=1 WIDTH=1");
    sel = 1;
    randomRun(1, 8'h01, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
